dft_bin_acc: RTL and testbench
==============================

// Module: dft_bin_acc
// PURPOSE
//  Single-bin DFT accumulator directly downstream of the per-row NCO. Mixes each
//  audio sample with the NCO's cos0/sin0 phasor and accumulates one frame, then
//  outputs one spectrogram pixel: the bin power, linear or log-compressed.
//  The pixel goes to the display line buffer; one instance per v_pos row slot.
// PARAMETERS
//  N_SAMPLES  256  samples per frame; power of two, 2..4096
//  ACC_W      42   accumulator width; must be >= 34+log2(N_SAMPLES)
//  ACC_SHIFT  18   arithmetic right shift from accumulator to 18-bit operand
//  PWR_SHIFT  28   right shift from 36-bit power to linear pixel
//  PIX_W      8    pixel width; must be 8 when DFT_LOG_EN is defined
// PORTS
//  CK            in   1   clock, all logic on posedge
//  RST_N         in   1   asynchronous reset, active low
//  START         in   1   one-cycle pulse: clear accumulators, begin frame
//  SAMPLE_VALID  in   1   sample/cos0/sin0 valid this cycle
//  sample        in   16  signed audio sample
//  cos0          in   18  signed Q1.17 NCO cosine, aligned with SAMPLE_VALID
//  sin0          in   18  signed Q1.17 NCO sine, aligned with SAMPLE_VALID
//  BUSY          out  1   high from START until PIX_VALID, inclusive
//  PIX_VALID     out  1   one-cycle pulse: PIX holds a new pixel
//  PIX           out  PIX_W  pixel value, held until the next PIX_VALID
// BEHAVIOUR
//  Reset, RST_N low: state IDLE; acc_re, acc_im, count, PIX, PIX_VALID and BUSY all 0.
//  FSM states: IDLE -> ACC -> SQ_RE -> SQ_IM -> OUT -> IDLE.
//   IDLE: wait for START. START in any state goes to ACC, zeroes acc_re, acc_im and count.
//   ACC: on each SAMPLE_VALID,
//    acc_re += sample*cos0 and acc_im -= sample*sin0, giving e^-jwt;
//    34-bit signed products are sign-extended to ACC_W; count++.
//    When count reaches N_SAMPLES-1 and a sample is accepted, next state is SQ_RE.
//    SAMPLE_VALID is ignored in all states except ACC.
//   SQ_RE: re_s = sat18(acc_re >>> ACC_SHIFT); pwr <= re_s*re_s (unsigned 36b).
//   SQ_IM: im_s = sat18(acc_im >>> ACC_SHIFT); pwr <= pwr + im_s*im_s.
//    The sum saturates at 36'hF_FFFF_FFFF.
//   OUT: PIX <= f(pwr); PIX_VALID=1 for this cycle only; next state IDLE.
//  sat18 clamps to [-131071, +131071]; -131072 is never produced.
//  Latency: PIX_VALID is high in the cycle after the 3rd posedge following the
//   edge that accepted the last sample.
//  One multiplier is time-shared: a 16x18 product in ACC, an 18x18 product in SQ_*.
//  START and SAMPLE_VALID in the same cycle: START wins, that sample is discarded.
//  START during SQ_RE, SQ_IM or OUT: the frame is aborted, no PIX_VALID, ACC restarts.
//  RST_N asserted mid-frame: immediate return to reset values.
//   After release the block stays IDLE until START.
//  Accumulators never wrap within the ACC_W constraint; overflow beyond it is undefined.
// CONFIGURATION
//  DFT_LOG_EN defined:
//   PIX = {e[5:0], m[1:0]}; e = index of the leading one of pwr, m = the 2 bits
//   below it (zero-filled); pwr==0 -> PIX=0. PWR_SHIFT is unused.
//  DFT_LOG_EN undefined:
//   PIX = min(pwr >> PWR_SHIFT, 2^PIX_W-1), a linear saturating value.
// TESTING
//  1 Linear: START, 256 samples of 1024 with cos0=65536, sin0=0 -> acc_re=2^34,
//    re_s=65536, PIX=16, one PIX_VALID 3 edges after last sample.
//  2 Sign: 256 samples of 1024, cos0=0, sin0=65536 -> acc_im=-2^34, PIX=16.
//    Zero input -> PIX=0.
//  3 Saturation: 256 samples of 32767, cos0=131071, sin0=0 -> re_s=131071,
//    PIX=63 linear; with DFT_LOG_EN, PIX=8'h87 (e=33, m=3).
//  4 Log: repeat test 1 with DFT_LOG_EN -> PIX=8'h80. BUSY high START..PIX_VALID.
//  5 START mid-frame after 100 samples, plus a START+SAMPLE_VALID collision ->
//    no PIX_VALID until 256 samples after the last START; result as in test 1.
//  6 RST_N low for 2 cycles at sample 100 -> PIX=0, PIX_VALID=0, BUSY=0;
//    further samples ignored until START.

Source files
------------

// File: rtl/dft_bin_acc.sv
// Single-bin DFT accumulator: mixes samples with the NCO phasor over one frame and
// emits one power pixel. Define DFT_LOG_EN for a log-compressed pixel, else linear.
module dft_bin_acc #(
    parameter int N_SAMPLES = 256,
    parameter int ACC_W     = 42,
    parameter int ACC_SHIFT = 18,
    parameter int PWR_SHIFT = 28,
    parameter int PIX_W     = 8
) (
    input  logic                    CK,
    input  logic                    RST_N,
    input  logic                    START,
    input  logic                    SAMPLE_VALID,
    input  logic signed [15:0]      sample,
    input  logic signed [17:0]      cos0,
    input  logic signed [17:0]      sin0,
    output logic                    BUSY,
    output logic                    PIX_VALID,
    output logic [PIX_W-1:0]        PIX
);

    localparam int CNT_W = (N_SAMPLES > 2) ? $clog2(N_SAMPLES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_SAMPLES - 1);
    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(131071);
    localparam logic signed [ACC_W-1:0] SAT_LO = -ACC_W'(131071);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ACC   = 3'd1,
        SQ_RE = 3'd2,
        SQ_IM = 3'd3,
        OUT   = 3'd4
    } state_e;

    state_e                   state_q, state_d;
    logic signed [ACC_W-1:0]  accRe_q, accRe_d;
    logic signed [ACC_W-1:0]  accIm_q, accIm_d;
    logic [CNT_W-1:0]         count_q, count_d;
    logic [35:0]              pwr_q, pwr_d;
    logic [PIX_W-1:0]         pix_q, pix_d;
    logic                     pixValid_q, pixValid_d;

    logic signed [17:0]       reSat, imSat;
    logic signed [17:0]       mulA, mulB;
    logic signed [35:0]       prodShared;
    logic signed [33:0]       prodIm;
    logic [35:0]              square;
    logic [36:0]              pwrSum;
    logic [PIX_W-1:0]         pixF;

    // Symmetric clamp so the square of either extreme stays below 2^34.
    function automatic logic signed [17:0] sat18(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] s;
        s = a >>> ACC_SHIFT;
        if (s > SAT_HI) begin
            return 18'sd131071;
        end else if (s < SAT_LO) begin
            return -18'sd131071;
        end
        return s[17:0];
    endfunction

    assign reSat = sat18(accRe_q);
    assign imSat = sat18(accIm_q);

    // The cosine-path multiplier doubles as the squarer once the frame is in.
    always_comb begin
        mulA = {{2{sample[15]}}, sample};
        mulB = cos0;
        case (state_q)
            SQ_RE: begin
                mulA = reSat;
                mulB = reSat;
            end
            SQ_IM: begin
                mulA = imSat;
                mulB = imSat;
            end
            default: ;
        endcase
    end

    assign prodShared = mulA * mulB;
    assign prodIm     = sample * sin0;
    assign square     = $unsigned(prodShared);
    assign pwrSum     = {1'b0, pwr_q} + {1'b0, square};

`ifdef DFT_LOG_EN
    // Exponent is the leading-one position, mantissa the two bits beneath it.
    always_comb begin
        logic [7:0] logPix;
        logPix = 8'd0;
        if (pwr_q[1]) begin
            logPix = {6'd1, pwr_q[0], 1'b0};
        end
        for (int i = 2; i < 36; i++) begin
            if (pwr_q[i]) begin
                logPix = {6'(i), pwr_q[i-1 -: 2]};
            end
        end
        pixF = PIX_W'(logPix);
    end
`else
    always_comb begin
        logic [35:0] shifted;
        shifted = pwr_q >> PWR_SHIFT;
        if (shifted > 36'((64'd1 << PIX_W) - 64'd1)) begin
            pixF = '1;
        end else begin
            pixF = shifted[PIX_W-1:0];
        end
    end
`endif

    // START takes priority over everything, including a sample in the same cycle.
    always_comb begin
        state_d    = state_q;
        accRe_d    = accRe_q;
        accIm_d    = accIm_q;
        count_d    = count_q;
        pwr_d      = pwr_q;
        pix_d      = pix_q;
        pixValid_d = 1'b0;
        if (START) begin
            state_d = ACC;
            accRe_d = '0;
            accIm_d = '0;
            count_d = '0;
        end else begin
            case (state_q)
                ACC: begin
                    if (SAMPLE_VALID) begin
                        accRe_d = accRe_q + ACC_W'(prodShared);
                        accIm_d = accIm_q - ACC_W'(prodIm);
                        count_d = count_q + CNT_W'(1);
                        if (count_q == LAST_CNT) begin
                            state_d = SQ_RE;
                        end
                    end
                end
                SQ_RE: begin
                    pwr_d   = square;
                    state_d = SQ_IM;
                end
                SQ_IM: begin
                    pwr_d   = pwrSum[36] ? 36'hF_FFFF_FFFF : pwrSum[35:0];
                    state_d = OUT;
                end
                OUT: begin
                    pix_d      = pixF;
                    pixValid_d = 1'b1;
                    state_d    = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= IDLE;
            accRe_q    <= '0;
            accIm_q    <= '0;
            count_q    <= '0;
            pwr_q      <= '0;
            pix_q      <= '0;
            pixValid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            accRe_q    <= accRe_d;
            accIm_q    <= accIm_d;
            count_q    <= count_d;
            pwr_q      <= pwr_d;
            pix_q      <= pix_d;
            pixValid_q <= pixValid_d;
        end
    end

    // Busy stays up through the cycle in which the pixel is presented.
    assign BUSY      = (state_q != IDLE) || pixValid_q;
    assign PIX_VALID = pixValid_q;
    assign PIX       = pix_q;

endmodule

// File: tb/tb_dft_bin_acc.sv
// Directed bench for dft_bin_acc: frame-level scoreboard of expected pixels plus
// latency, BUSY, abort and reset checks. Honours DFT_LOG_EN like the design.
module tb_dft_bin_acc;

    localparam int N = 256;
`ifdef DFT_LOG_EN
    localparam logic [31:0] EXP_UNIT = 32'h80;
    localparam logic [31:0] EXP_SAT  = 32'h87;
`else
    localparam logic [31:0] EXP_UNIT = 32'd16;
    localparam logic [31:0] EXP_SAT  = 32'd63;
`endif

    logic               CK = 1'b0;
    logic               RST_N;
    logic               START;
    logic               SAMPLE_VALID;
    logic signed [15:0] sample;
    logic signed [17:0] cos0;
    logic signed [17:0] sin0;
    logic               BUSY;
    logic               PIX_VALID;
    logic [7:0]         PIX;

    int checks   = 0;
    int failures = 0;
    int pixSeen  = 0;
    int pushed   = 0;

    logic [31:0] expQ[$];
    longint      mRe, mIm;
    int          mCount;
    bit          mActive   = 0;
    bit          pending   = 0;
    int          sinceLast = 0;

    dft_bin_acc dut (
        .CK           (CK),
        .RST_N        (RST_N),
        .START        (START),
        .SAMPLE_VALID (SAMPLE_VALID),
        .sample       (sample),
        .cos0         (cos0),
        .sin0         (sin0),
        .BUSY         (BUSY),
        .PIX_VALID    (PIX_VALID),
        .PIX          (PIX)
    );

    always #5 CK = ~CK;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic longint sat18(input longint a);
        longint s;
        s = a >>> 18;
        if (s > 131071) s = 131071;
        if (s < -131071) s = -131071;
        return s;
    endfunction

    function automatic logic [31:0] modelPix(input longint re, input longint im);
        longint r, i, p;
        int e;
        r = sat18(re);
        i = sat18(im);
        p = r * r + i * i;
        if (p > 64'hF_FFFF_FFFF) p = 64'hF_FFFF_FFFF;
`ifdef DFT_LOG_EN
        if (p == 0) return 32'd0;
        e = 0;
        for (int b = 35; b >= 0; b--) begin
            if (((p >> b) & 1) != 0) begin
                e = b;
                break;
            end
        end
        if (e >= 2) return 32'((e << 2) | ((p >> (e - 2)) & 3));
        return 32'((e << 2) | ((p << (2 - e)) & 3));
`else
        p = p >> 28;
        if (p > 255) p = 255;
        return 32'(p);
`endif
    endfunction

    // One clock of stimulus; the frame model tracks what the DUT should accept.
    task automatic applyStimulus(input logic st, input logic v, input logic signed [15:0] s,
                                 input logic signed [17:0] c, input logic signed [17:0] sn);
        START        = st;
        SAMPLE_VALID = v;
        sample       = s;
        cos0         = c;
        sin0         = sn;
        @(posedge CK);
        if (pending) begin
            sinceLast++;
            if (st) begin
                void'(expQ.pop_back());
                pushed--;
                pending = 0;
            end else if (sinceLast >= 3) begin
                pending = 0;
            end
        end
        if (st) begin
            mActive = 1;
            mRe     = 0;
            mIm     = 0;
            mCount  = 0;
        end else if (v && mActive) begin
            mRe += longint'(s) * longint'(c);
            mIm -= longint'(s) * longint'(sn);
            mCount++;
            if (mCount == N) begin
                expQ.push_back(modelPix(mRe, mIm));
                pushed++;
                mActive   = 0;
                pending   = 1;
                sinceLast = 0;
            end
        end
        #1;
        START        = 1'b0;
        SAMPLE_VALID = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0, 16'sd0, 18'sd0, 18'sd0);
    endtask

    task automatic samples(input int n, input logic signed [15:0] s,
                           input logic signed [17:0] c, input logic signed [17:0] sn);
        for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b1, s, c, sn);
    endtask

    // Last sample already accepted: pixel must appear exactly after the third edge.
    task automatic checkLatency(input string tag, input logic [31:0] expPix);
        idle(1);
        checkOutput({tag, "_pv_e1"}, 32'(PIX_VALID), 32'd0);
        idle(1);
        checkOutput({tag, "_pv_e2"}, 32'(PIX_VALID), 32'd0);
        checkOutput({tag, "_busy_e2"}, 32'(BUSY), 32'd1);
        idle(1);
        checkOutput({tag, "_pv_e3"}, 32'(PIX_VALID), 32'd1);
        checkOutput({tag, "_busy_e3"}, 32'(BUSY), 32'd1);
        checkOutput({tag, "_pix"}, 32'(PIX), expPix);
        idle(1);
        checkOutput({tag, "_pv_e4"}, 32'(PIX_VALID), 32'd0);
        checkOutput({tag, "_busy_e4"}, 32'(BUSY), 32'd0);
    endtask

    always @(negedge CK) begin
        if (RST_N === 1'b1 && PIX_VALID === 1'b1) begin
            pixSeen++;
            if (expQ.size() == 0) begin
                checkOutput("pix_without_expectation", 32'(expQ.size()), 32'd1);
            end else begin
                checkOutput("scoreboard_pix", 32'(PIX), expQ.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int seenBefore;
        int r, c, sn;
        RST_N        = 1'b0;
        START        = 1'b0;
        SAMPLE_VALID = 1'b0;
        sample       = '0;
        cos0         = '0;
        sin0         = '0;
        repeat (2) @(posedge CK);
        #1;
        checkOutput("reset_pix", 32'(PIX), 32'd0);
        checkOutput("reset_pv", 32'(PIX_VALID), 32'd0);
        checkOutput("reset_busy", 32'(BUSY), 32'd0);
        RST_N = 1'b1;
        idle(2);
        checkOutput("idle_busy", 32'(BUSY), 32'd0);

        $display("[TB] linear cosine frame");
        applyStimulus(1'b1, 1'b0, 16'sd0, 18'sd0, 18'sd0);
        checkOutput("start_busy", 32'(BUSY), 32'd1);
        samples(N, 16'sd1024, 18'sd65536, 18'sd0);
        checkLatency("t1", EXP_UNIT);
        idle(3);
        checkOutput("t1_pix_held", 32'(PIX), EXP_UNIT);

        $display("[TB] sine sign frame");
        applyStimulus(1'b1, 1'b0, 16'sd0, 18'sd0, 18'sd0);
        samples(N, 16'sd1024, 18'sd0, 18'sd65536);
        checkLatency("t2", EXP_UNIT);

        $display("[TB] zero frame");
        applyStimulus(1'b1, 1'b0, 16'sd0, 18'sd0, 18'sd0);
        samples(N, 16'sd0, 18'sd65536, 18'sd65536);
        checkLatency("t2z", 32'd0);

        $display("[TB] saturating frame");
        applyStimulus(1'b1, 1'b0, 16'sd0, 18'sd0, 18'sd0);
        samples(N, 16'sd32767, 18'sd131071, 18'sd0);
        checkLatency("t3", EXP_SAT);

        $display("[TB] restart mid-frame with collision");
        seenBefore = pixSeen;
        applyStimulus(1'b1, 1'b0, 16'sd0, 18'sd0, 18'sd0);
        samples(100, 16'sd1024, 18'sd65536, 18'sd0);
        applyStimulus(1'b1, 1'b0, 16'sd0, 18'sd0, 18'sd0);
        samples(50, -16'sd3000, 18'sd65536, 18'sd0);
        applyStimulus(1'b1, 1'b1, 16'sd32767, 18'sd131071, 18'sd131071);
        samples(N - 1, 16'sd1024, 18'sd65536, 18'sd0);
        checkOutput("t5_no_early_pix", 32'(pixSeen), 32'(seenBefore));
        samples(1, 16'sd1024, 18'sd65536, 18'sd0);
        checkLatency("t5", EXP_UNIT);

        $display("[TB] abort during squaring");
        seenBefore = pixSeen;
        applyStimulus(1'b1, 1'b0, 16'sd0, 18'sd0, 18'sd0);
        samples(N, 16'sd1024, 18'sd65536, 18'sd0);
        idle(1);
        applyStimulus(1'b1, 1'b0, 16'sd0, 18'sd0, 18'sd0);
        idle(4);
        checkOutput("abort_no_pix", 32'(pixSeen), 32'(seenBefore));
        samples(N, -16'sd512, -18'sd65536, 18'sd32768);
        checkLatency("abort_restart", modelPix(longint'(N) * 512 * 65536, longint'(N) * 512 * 32768));

        $display("[TB] reset mid-frame");
        applyStimulus(1'b1, 1'b0, 16'sd0, 18'sd0, 18'sd0);
        samples(100, 16'sd1024, 18'sd65536, 18'sd0);
        RST_N   = 1'b0;
        mActive = 0;
        #1;
        checkOutput("rst_pix", 32'(PIX), 32'd0);
        checkOutput("rst_busy", 32'(BUSY), 32'd0);
        repeat (2) @(posedge CK);
        #1;
        checkOutput("rst_pv", 32'(PIX_VALID), 32'd0);
        RST_N = 1'b1;
        seenBefore = pixSeen;
        samples(N + 20, 16'sd1024, 18'sd65536, 18'sd0);
        idle(4);
        checkOutput("rst_ignored_busy", 32'(BUSY), 32'd0);
        checkOutput("rst_ignored_pix", 32'(pixSeen), 32'(seenBefore));

        $display("[TB] random frames");
        for (int f = 0; f < 2; f++) begin
            applyStimulus(1'b1, 1'b0, 16'sd0, 18'sd0, 18'sd0);
            for (int k = 0; k < N; k++) begin
                r  = int'($urandom_range(0, 4095)) - 2048;
                c  = int'($urandom_range(0, 262142)) - 131071;
                sn = int'($urandom_range(0, 262142)) - 131071;
                if ((k % 7) == 3) idle(1);
                applyStimulus(1'b0, 1'b1, 16'(r), 18'(c), 18'(sn));
            end
            idle(5);
        end

        checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
        checkOutput("pix_count", 32'(pixSeen), 32'(pushed));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
